// File: rtl/mem_loader_if.sv
// Byte-stream-to-memory loader bus: control, byte handshake and memory write port.
// master drives start/length/bytes; slave is the loader itself.
interface mem_loader_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12
);
  logic                     start;
  logic [ADDRESS_WIDTH:0]   num_words;
  logic                     byte_valid;
  logic [7:0]               byte_data;
  logic                     byte_ready;
  logic                     mem_wEn;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_dataIn;
  logic                     busy;
  logic                     done;
  logic [ADDRESS_WIDTH:0]   words_written;

  modport master (
    output start, num_words, byte_valid, byte_data,
    input  byte_ready, mem_wEn, mem_addr, mem_dataIn, busy, done, words_written
  );

  modport slave (
    input  start, num_words, byte_valid, byte_data,
    output byte_ready, mem_wEn, mem_addr, mem_dataIn, busy, done, words_written
  );
endinterface

// File: rtl/mem_loader.sv
// Packs an incoming byte stream big-endian into 32-bit words and writes them
// to consecutive memory addresses, one single-cycle strobe per word.
module mem_loader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int DEPTH         = 4096
) (
  input logic         clk,
  input logic         reset_n,
  mem_loader_if.slave bus
);

  localparam logic [ADDRESS_WIDTH:0]   DEPTH_L   = (ADDRESS_WIDTH+1)'(DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } state_e;

  state_e                   state_q;
  logic [1:0]               cnt_q;
  logic [ADDRESS_WIDTH:0]   len_q;
  logic [ADDRESS_WIDTH:0]   words_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic                     ready_q;
  logic                     wen_q;
  logic                     busy_q;
  logic                     done_q;

  logic [ADDRESS_WIDTH:0]   len_d;
  logic [ADDRESS_WIDTH:0]   words_d;
  logic [DATA_WIDTH-1:0]    data_d;

  always_comb begin
    len_d   = (bus.num_words > DEPTH_L) ? DEPTH_L : bus.num_words;
    words_d = words_q + (ADDRESS_WIDTH+1)'(1);
    // shifting in at the bottom leaves byte 0 in the top lane after four bytes
    data_d  = {data_q[DATA_WIDTH-9:0], bus.byte_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      words_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      wen_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      wen_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            len_q   <= len_d;
            addr_q  <= '0;
            words_q <= '0;
            cnt_q   <= '0;
            if (len_d == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              ready_q <= 1'b0;
            end else begin
              state_q <= COLLECT;
              done_q  <= 1'b0;
              busy_q  <= 1'b1;
              ready_q <= 1'b1;
            end
          end
        end

        COLLECT: begin
          if (bus.byte_valid && ready_q) begin
            data_q <= data_d;
            cnt_q  <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              state_q <= WRITE;
              ready_q <= 1'b0;
              wen_q   <= 1'b1;
            end
          end
        end

        WRITE: begin
          cnt_q   <= '0;
          words_q <= words_d;
          // saturate at the top word so a full-depth load cannot wrap to 0
          if (addr_q != LAST_ADDR) begin
            addr_q <= addr_q + ADDRESS_WIDTH'(1);
          end
          if (words_d == len_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= COLLECT;
            ready_q <= 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.byte_ready    = ready_q;
  assign bus.mem_wEn       = wen_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_dataIn    = data_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.words_written = words_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: a queue model of expected writes derived from
// the byte image, checked on every negedge, plus literal end-of-load checks.
module tb_mem_loader;
  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mem_loader_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  mem_loader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int unsigned   vectors     = 0;
  int unsigned   miscompares = 0;
  int            cyc         = 0;
  logic [7:0]    img[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];
  int            nwrites_load = 0;
  int            last_wen_cyc = 0;
  int            last_gap     = 0;
  logic [DW-1:0] last_wdata   = '0;
  logic [AW-1:0] last_waddr   = '0;
  logic [AW-1:0] prev_addr    = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] img_word(input int i);
    return {img[4*i], img[4*i+1], img[4*i+2], img[4*i+3]};
  endfunction

  // Expected write sequence for a load of n words from the current image.
  task automatic expect_load(input int n);
    int m = (n > DEPTH) ? DEPTH : n;
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int i = 0; i < m; i++) begin
      exp_addr_q.push_back(AW'(i));
      exp_data_q.push_back(img_word(i));
    end
    nwrites_load = 0;
    prev_addr    = '0;
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      chk("busy_done_exclusive", {63'd0, bus.busy & bus.done}, 64'd0);
      chk("ready_implies_busy", {63'd0, bus.byte_ready & ~bus.busy}, 64'd0);
      if (bus.busy) begin
        chk("ready_low_only_in_write", {63'd0, bus.byte_ready}, {63'd0, ~bus.mem_wEn});
        chk("addr_no_wrap", {63'd0, bus.mem_addr >= prev_addr}, 64'd1);
        prev_addr = bus.mem_addr;
      end
      if (bus.mem_wEn) begin
        chk("write_expected", {63'd0, exp_addr_q.size() != 0}, 64'd1);
        if (exp_addr_q.size() != 0) begin
          chk("wr_addr", 64'(bus.mem_addr), 64'(exp_addr_q.pop_front()));
          chk("wr_data", 64'(bus.mem_dataIn), 64'(exp_data_q.pop_front()));
        end
        if (nwrites_load > 0) last_gap = cyc - last_wen_cyc;
        last_wen_cyc = cyc;
        nwrites_load++;
        last_wdata = bus.mem_dataIn;
        last_waddr = bus.mem_addr;
      end
    end
  end

  // Called at a negedge; returns at a negedge after the start edge.
  task automatic do_start(input int n);
    bus.start     = 1'b1;
    bus.num_words = (AW+1)'(n);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Holds the byte until a cycle with byte_ready=1, then it transfers at the next posedge.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (bus.byte_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) chk("byte_accept_timeout", {63'd0, bus.byte_ready}, 64'd1);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic send_img(input int nbytes, input bit gap);
    for (int k = 0; k < nbytes; k++) send_byte(img[k], gap);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (bus.done !== 1'b1 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, {63'd0, bus.done}, 64'd1);
  endtask

  task automatic set_img(input logic [31:0] w0, input logic [31:0] w1);
    logic [63:0] v = {w0, w1};
    img.delete();
    for (int k = 0; k < 8; k++) img.push_back(v[63-8*k -: 8]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n        = 1'b0;
    bus.start      = 1'b0;
    bus.num_words  = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {63'd0, bus.byte_ready}, 64'd0);
    chk("rst_wen", {63'd0, bus.mem_wEn}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_data", 64'(bus.mem_dataIn), 64'd0);
    chk("rst_words", 64'(bus.words_written), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", {63'd0, bus.byte_ready}, 64'd0);

    // Two words, bytes back to back
    set_img(32'h12345678, 32'h9ABCDEF0);
    chk("model_word0", 64'(img_word(0)), 64'h12345678);
    chk("model_word1", 64'(img_word(1)), 64'h9ABCDEF0);
    expect_load(2);
    do_start(2);
    chk("t1_busy", {63'd0, bus.busy}, 64'd1);
    chk("t1_ready", {63'd0, bus.byte_ready}, 64'd1);
    send_img(8, 1'b0);
    wait_done("t1");
    chk("t1_words", 64'(bus.words_written), 64'd2);
    chk("t1_nwrites", 64'(nwrites_load), 64'd2);
    chk("t1_gap", 64'(last_gap), 64'd5);
    chk("t1_last_data", 64'(last_wdata), 64'h9ABCDEF0);
    chk("t1_last_addr", 64'(last_waddr), 64'd1);
    chk("t1_addr_after", 64'(bus.mem_addr), 64'd2);
    chk("t1_busy_after", {63'd0, bus.busy}, 64'd0);
    chk("t1_queue_empty", 64'(exp_addr_q.size()), 64'd0);

    // Same load with byte_valid toggling
    expect_load(2);
    do_start(2);
    chk("t2_done_dropped", {63'd0, bus.done}, 64'd0);
    send_img(8, 1'b1);
    wait_done("t2");
    chk("t2_words", 64'(bus.words_written), 64'd2);
    chk("t2_nwrites", 64'(nwrites_load), 64'd2);
    chk("t2_last_data", 64'(last_wdata), 64'h9ABCDEF0);

    // Zero-length load
    expect_load(0);
    do_start(0);
    chk("t3_done", {63'd0, bus.done}, 64'd1);
    chk("t3_busy", {63'd0, bus.busy}, 64'd0);
    chk("t3_words", 64'(bus.words_written), 64'd0);
    repeat (5) @(negedge clk);
    chk("t3_nwrites", 64'(nwrites_load), 64'd0);
    chk("t3_addr", 64'(bus.mem_addr), 64'd0);

    // Oversized request clamps to DEPTH
    img.delete();
    for (int k = 0; k < 4 * DEPTH; k++) img.push_back(8'(k * 37 + k / 256));
    chk("model_big_word0", 64'(img_word(0)), 64'h00254A6F);
    expect_load(5000);
    do_start(5000);
    send_img(4 * DEPTH, 1'b0);
    wait_done("t4");
    chk("t4_words", 64'(bus.words_written), 64'd4096);
    chk("t4_nwrites", 64'(nwrites_load), 64'd4096);
    chk("t4_last_addr", 64'(last_waddr), 64'd4095);
    chk("t4_addr_after", 64'(bus.mem_addr), 64'd4095);
    chk("t4_queue_empty", 64'(exp_addr_q.size()), 64'd0);

    // Reset after the 2nd byte of the 3rd word
    img.delete();
    for (int k = 0; k < 16; k++) img.push_back(8'(8'h10 + k));
    expect_load(4);
    do_start(4);
    send_img(10, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_ready", {63'd0, bus.byte_ready}, 64'd0);
    chk("t5_wen", {63'd0, bus.mem_wEn}, 64'd0);
    chk("t5_busy", {63'd0, bus.busy}, 64'd0);
    chk("t5_addr", 64'(bus.mem_addr), 64'd0);
    chk("t5_data", 64'(bus.mem_dataIn), 64'd0);
    chk("t5_words", 64'(bus.words_written), 64'd0);
    chk("t5_nwrites", 64'(nwrites_load), 64'd2);
    chk("t5_last_addr", 64'(last_waddr), 64'd1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("t5_nwrites_after", 64'(nwrites_load), 64'd2);
    set_img(32'hA1B2C3D4, 32'h0);
    expect_load(1);
    do_start(1);
    send_img(4, 1'b0);
    wait_done("t5b");
    chk("t5b_addr", 64'(last_waddr), 64'd0);
    chk("t5b_data", 64'(last_wdata), 64'hA1B2C3D4);
    chk("t5b_words", 64'(bus.words_written), 64'd1);

    // Start pulses while busy are ignored; num_words changes after capture too
    set_img(32'h01020304, 32'h05060708);
    expect_load(2);
    do_start(2);
    fork
      send_img(8, 1'b0);
      begin
        repeat (2) @(negedge clk);
        bus.start     = 1'b1;
        bus.num_words = (AW+1)'(1);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.start     = 1'b1;
        bus.num_words = '0;
        @(negedge clk);
        bus.start = 1'b0;
      end
    join
    wait_done("t6");
    chk("t6_words", 64'(bus.words_written), 64'd2);
    chk("t6_nwrites", 64'(nwrites_load), 64'd2);
    chk("t6_last_data", 64'(last_wdata), 64'h05060708);

    // Restart from DONE
    set_img(32'hDEADBEEF, 32'h0);
    expect_load(1);
    do_start(1);
    chk("t6b_done_clear", {63'd0, bus.done}, 64'd0);
    chk("t6b_busy", {63'd0, bus.busy}, 64'd1);
    send_img(4, 1'b0);
    wait_done("t6b");
    chk("t6b_data", 64'(last_wdata), 64'hDEADBEEF);
    chk("t6b_addr", 64'(last_waddr), 64'd0);
    chk("t6b_words", 64'(bus.words_written), 64'd1);
    chk("t6b_nwrites", 64'(nwrites_load), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Writer-side counterpart to the instruction/data ROM. Accepts a byte stream over a valid/ready handshake and packs each 4 bytes into a 32-bit word.
- Issues single-cycle write strobes at incrementing addresses into a RAM-style memory array. That array is later read word-by-word by the fetch path.
- Lets a program image be loaded at run time over a serial/byte link instead of through a memory file.

Parameters:
- DATA_WIDTH, 32, memory word width; must be 32 (four bytes per word).
- ADDRESS_WIDTH, 12, memory address width.
- DEPTH, 4096, number of words in the target memory; load length is clamped to this.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a load; sampled in IDLE or DONE only.
- num_words  input  ADDRESS_WIDTH+1  words to load; captured on accepted start.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  incoming byte.
- byte_ready  output  1  loader can accept a byte this cycle.
- mem_wEn  output  1  write strobe to memory, one cycle per word.
- mem_addr  output  ADDRESS_WIDTH  write address.
- mem_dataIn  output  DATA_WIDTH  write data.
- busy  output  1  load in progress (COLLECT or WRITE).
- done  output  1  load complete; held until next accepted start.
- words_written  output  ADDRESS_WIDTH+1  count of words committed in the current/last load.

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - byte_ready, mem_wEn, busy and done are 0; mem_addr, mem_dataIn and words_written are 0.
  - Internal byte counter and length register are 0.
  - Reset mid-load abandons the load immediately; no further mem_wEn.
- State machine:
  - IDLE: byte_ready=0. start=1 moves to COLLECT, or to DONE if the captured length is 0. It also clears mem_addr, words_written and the byte count.
  - COLLECT: byte_ready=1, busy=1. A byte transfers on a posedge with byte_valid & byte_ready. Packing is big-endian: byte 0 goes to bits 31:24, byte 3 to bits 7:0, assembled in mem_dataIn. After the 4th byte, go to WRITE.
  - WRITE: byte_ready=0, busy=1, mem_wEn=1 for exactly one cycle with the current mem_addr/mem_dataIn. On the next edge, mem_addr increments, words_written increments and the byte count clears. If words_written+1 equals the captured length, go to DONE; otherwise go to COLLECT.
  - DONE: done=1, busy=0, byte_ready=0, outputs frozen. start=1 begins a new load exactly as from IDLE; done drops the same edge.
- Length capture:
  - Captured length = min(num_words, DEPTH).
  - num_words changes after capture are ignored.
  - mem_addr never exceeds DEPTH-1 and never wraps.
- start while busy is ignored.
- byte_valid while byte_ready=0 (IDLE, WRITE, DONE) is not consumed. The source must hold the byte until accepted.
- Latency and throughput:
  - The 4th byte accepted at posedge N gives mem_wEn=1 from N until N+1.
  - Sustained throughput is one word per 5 cycles with byte_valid held high.
- Data hold:
  - mem_dataIn and mem_addr are stable throughout the mem_wEn cycle.
  - Memory samples on posedge; the fetch-side read on negedge is unaffected.
- Source stalls: gaps in byte_valid stall COLLECT indefinitely with no timeout. A partially assembled word is retained across stalls.

Test Plan:
- Reset, start with num_words=2, bytes 0x12,0x34,0x56,0x78,0x9A,0xBC,0xDE,0xF0 valid every cycle:
  - writes 0x12345678 at addr 0 and 0x9ABCDEF0 at addr 1;
  - one mem_wEn pulse per word, 5 cycles apart;
  - then done=1, words_written=2.
- Same load with byte_valid toggled 1/0 each cycle: identical writes; byte_ready drops only in WRITE; no byte lost or duplicated.
- start with num_words=0: goes directly to DONE; mem_wEn never asserts; words_written=0.
- num_words=5000 with DEPTH=4096:
  - exactly 4096 writes, addresses 0..4095;
  - done=1 after the last write; mem_addr never wraps to 0 during the load.
- reset_n asserted after the 2nd byte of word 3: all outputs go to 0 asynchronously and no write to addr 2 occurs. A new start after release loads from addr 0.
- start pulses during busy: ignored. start in DONE with num_words=1 and bytes 0xDEADBEEF: done clears; single write 0xDEADBEEF at addr 0.
